qspi_target: RTL
================

# qspi_target

Synthesizable QSPI memory responder: the target end of the quad-SPI link driven by the CPU's `qspi` controller. It decodes the controller's quad command/address/data stream and serves reads and writes from a byte-wide synchronous memory port. It lets simulation benches and FPGA builds stand in for external flash/PSRAM, and runs on the same clock the controller exports as the SPI clock.

## Interface
- `AW`, 24: address width in bits; the memory port is `AW` bits wide.
- `DUMMY`, 6: read dummy nibble cycles; must be ≥2.
- `RD_CMD`, 8'hEB: quad read opcode.
- `WR_CMD`, 8'h38: quad write opcode.
- `clk`  in  1  SPI/system clock, shared with the controller.
- `reset`  in  1  asynchronous, active-low reset.
- `cs_n`  in  1  chip select, active low.
- `qd_in`  in  4  quad data from the controller.
- `qd_out`  out  4  quad data to the controller.
- `qd_oe`  out  4  per-lane output enable (all lanes equal).
- `mem_addr`  out  AW  byte address.
- `mem_re`  out  1  read strobe; `mem_rdata` is valid 1 cycle later.
- `mem_rdata`  in  8  read data.
- `mem_we`  out  1  write strobe, 1 cycle.
- `mem_wdata`  out  8  write data.
- `err`  out  1  1-cycle pulse on an unknown opcode.

## Operation
- All inputs are sampled on the rising edge of `clk`.
- Cycle 0 is the first edge with `cs_n`=0.
- Nibbles are sent most-significant first.
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
- IDLE → CMD on `cs_n`=0.
- CMD: cycles 0–1 capture the opcode.
  - Opcode is `RD_CMD` or `WR_CMD` → ADDR.
  - Any other opcode → IGNORE, with `err` pulsed in cycle 2.
- ADDR: cycles 2..(2+AW/4−1) capture the address. With AW=24 these are cycles 2–7.
  - After the last nibble, a read goes to DUMMY and a write goes to WDATA.
- DUMMY: holds for `DUMMY` cycles.
  - In the first DUMMY cycle, `mem_re`=1 with the captured address; the returned byte loads the output byte buffer.
  - In the second DUMMY cycle, `mem_re`=1 for address+1 (prefetch register).
- RDATA: one nibble is driven per cycle, high nibble then low.
  - On each low-nibble cycle, the prefetch register moves into the byte buffer.
  - On each low-nibble cycle, `mem_re` is issued for the next address.
  - This gives a continuous stream with no bubbles.
- WDATA: the high nibble is held; on the low nibble the byte is assembled.
  - The next cycle issues `mem_we`=1 with `mem_addr`/`mem_wdata`, then the address increments.
- The address increments modulo 2^AW, so 0xFFFFFF+1 = 0x000000.
- `cs_n`=1 at any edge returns the block to IDLE.
  - A partial write byte (high nibble only) is discarded; no `mem_we` is issued.
  - Outstanding read data is dropped.
- IGNORE holds until `cs_n`=1. Nothing is driven and no memory access is made.
- A fresh transaction may start on the edge immediately after a deassertion.

## Timing
- Reset values: state=IDLE, `qd_out`=0, `qd_oe`=0, `mem_re`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `err`=0.
- `qd_oe` = registered enable AND NOT `cs_n`, so the bus is released combinationally on deselect.
- Read, with AW=24:
  - Registered enable rises at the edge ending cycle 7+DUMMY.
  - First data nibble is valid throughout cycle 8+DUMMY (cycle 14 at the defaults).
  - Each later nibble is valid one cycle after the previous one.
- Write, with AW=24: the first data nibble is sampled in cycle 8.
  - Byte k's low nibble is sampled in cycle 9+2k.
  - `mem_we` for byte k is asserted in cycle 10+2k.
- `mem_re` and `mem_we` are never asserted together.
- `mem_re` and `mem_we` are never asserted while `cs_n`=1, except a `mem_we` already committed for a completed byte.

## Structure
- Package `qspi_pkg` holds:
  - the state enum;
  - `RD_CMD`/`WR_CMD` defaults;
  - command/address cycle-count constants;
  - these are shared with the `qspi` controller.
- Single module with no sub-module. The nibble shifter and the byte/prefetch buffers are small enough to inline.

## Test plan
- Preload mem[0x000100..0x000103]=11 22 33 44; send read EB, address 000100, then 8 data cycles → qd_out = 1,1,2,2,3,3,4,4, first nibble in cycle 14.
- Send write 38, address 000200, data nibbles A,5,C,3 → two `mem_we` pulses: (0x000200,0xA5) in cycle 10 and (0x000201,0xC3) in cycle 12.
- Read at 0xFFFFFF for 2 bytes, with mem[0xFFFFFF]=0x5A and mem[0]=0x7E → nibbles 5,A,7,E (wrap).
- Send opcode 0x03 → `err` pulse in cycle 2, `qd_oe`=0 throughout, no memory strobes until `cs_n` rises; the next EB read then works normally.
- Write one full byte plus one extra nibble, then raise `cs_n` → exactly one `mem_we`; the partial byte is dropped and `qd_oe`=0.
- Assert `reset`=0 mid-read → all outputs at reset values immediately; after release, a full read returns correct data.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared QSPI definitions: target state encoding, default opcodes and the
// nibble counts of the command/address phases used by controller and target.
package qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } qspi_state_e;

  localparam logic [7:0] QSPI_RD_CMD = 8'hEB;
  localparam logic [7:0] QSPI_WR_CMD = 8'h38;

  localparam int unsigned CMD_NIBBLES     = 2;
  localparam int unsigned BITS_PER_NIBBLE = 4;

  function automatic int unsigned addr_nibbles(input int unsigned aw);
    return aw / BITS_PER_NIBBLE;
  endfunction

endpackage

// File: rtl/qspi_target.sv
// Quad-SPI memory target: decodes opcode/address/data nibbles from the
// controller and serves a byte-wide synchronous memory with read prefetch.
module qspi_target
  import qspi_pkg::*;
#(
  parameter int unsigned AW     = 24,
  parameter int unsigned DUMMY  = 6,
  parameter logic [7:0]  RD_CMD = QSPI_RD_CMD,
  parameter logic [7:0]  WR_CMD = QSPI_WR_CMD
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs_n,
  input  logic [3:0]    qd_in,
  output logic [3:0]    qd_out,
  output logic [3:0]    qd_oe,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  input  logic [7:0]    mem_rdata,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  output logic          err
);

  localparam int unsigned       CNT_W      = 8;
  localparam logic [CNT_W-1:0]  ADDR_LAST  = CNT_W'(addr_nibbles(AW) - 1);
  localparam logic [CNT_W-1:0]  DUMMY_LAST = CNT_W'(DUMMY - 1);

  qspi_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic             is_rd;
  logic             first_rd;
  logic             lo_next;
  logic             oe_q;
  logic             mem_re_q;
  logic             re_d;
  logic [AW-1:0]    addr;
  logic [AW-1:0]    addr_full;
  logic [3:0]       cmd_hi;
  logic [3:0]       wr_hi;
  logic [3:0]       hi_nxt;
  logic [7:0]       opcode;
  logic [7:0]       byte_buf;
  logic [7:0]       prefetch;

  assign addr_full = {addr[AW-5:0], qd_in};
  assign opcode    = {cmd_hi, qd_in};
  // The first read byte may land on the same edge the bus turns around.
  assign hi_nxt    = (re_d && first_rd) ? mem_rdata[7:4] : byte_buf[7:4];
  assign qd_oe     = {4{oe_q & ~cs_n}};
  assign mem_re    = mem_re_q & ~cs_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      is_rd     <= 1'b0;
      first_rd  <= 1'b0;
      lo_next   <= 1'b0;
      oe_q      <= 1'b0;
      mem_re_q  <= 1'b0;
      re_d      <= 1'b0;
      addr      <= '0;
      qd_out    <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      err      <= 1'b0;
      mem_re_q <= 1'b0;
      mem_we   <= 1'b0;
      re_d     <= mem_re;
      if (cs_n) begin
        state    <= ST_IDLE;
        oe_q     <= 1'b0;
        qd_out   <= '0;
        lo_next  <= 1'b0;
        first_rd <= 1'b0;
        re_d     <= 1'b0;
        cnt      <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_CMD;
          end
          ST_CMD: begin
            cnt <= '0;
            if (opcode == RD_CMD) begin
              is_rd <= 1'b1;
              state <= ST_ADDR;
            end else if (opcode == WR_CMD) begin
              is_rd <= 1'b0;
              state <= ST_ADDR;
            end else begin
              err   <= 1'b1;
              state <= ST_IGNORE;
            end
          end
          ST_ADDR: begin
            addr <= addr_full;
            if (cnt == ADDR_LAST) begin
              cnt     <= '0;
              lo_next <= 1'b0;
              if (is_rd) begin
                state    <= ST_DUMMY;
                mem_re_q <= 1'b1;
                mem_addr <= addr_full;
                first_rd <= 1'b1;
              end else begin
                state <= ST_WDATA;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_DUMMY: begin
            // Second fetch fills the prefetch register ahead of the stream.
            if (cnt == '0) begin
              mem_re_q <= 1'b1;
              mem_addr <= addr + 1'b1;
              addr     <= addr + 1'b1;
            end
            if (re_d && first_rd) first_rd <= 1'b0;
            if (cnt == DUMMY_LAST) begin
              state   <= ST_RDATA;
              oe_q    <= 1'b1;
              qd_out  <= hi_nxt;
              lo_next <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_RDATA: begin
            if (lo_next) begin
              qd_out   <= byte_buf[3:0];
              mem_re_q <= 1'b1;
              mem_addr <= addr + 1'b1;
              addr     <= addr + 1'b1;
              lo_next  <= 1'b0;
            end else begin
              qd_out  <= prefetch[7:4];
              lo_next <= 1'b1;
            end
          end
          ST_WDATA: begin
            if (lo_next) begin
              mem_we    <= 1'b1;
              mem_wdata <= {wr_hi, qd_in};
              mem_addr  <= addr;
              addr      <= addr + 1'b1;
              lo_next   <= 1'b0;
            end else begin
              lo_next <= 1'b1;
            end
          end
          ST_IGNORE: begin
            state <= ST_IGNORE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Nibble holding and read buffering; contents are only consumed once loaded.
  always_ff @(posedge clk) begin
    if (!cs_n && state == ST_IDLE) cmd_hi <= qd_in;
    if (!cs_n && state == ST_WDATA && !lo_next) wr_hi <= qd_in;
    if (re_d) begin
      if (first_rd) byte_buf <= mem_rdata;
      else          prefetch <= mem_rdata;
    end
    if (!cs_n && state == ST_RDATA && !lo_next) byte_buf <= prefetch;
  end

endmodule
